// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the full-speed USB transmit path.
// Line states are encoded as {dp,dn}.
package usb_pkg;

  localparam int USB_STUFF_LIMIT = 6;
  localparam int USB_EOP_SE0_BITS = 2;

  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_K = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_ABORT
  } usb_fs_tx_state_t;

endpackage

// File: rtl/usb_fs_tx_nrzi.sv
// usb_fs_tx_nrzi: bit stuffing counter and NRZI line register.
// A stuffed 0 is inserted on the strobe after the sixth consecutive 1.
module usb_fs_tx_nrzi
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic bit_strobe,
  input  logic data_bit,
  input  logic no_stuff,
  input  logic force_se0,
  input  logic force_j,
  output logic stuff_now,
  output logic dp,
  output logic dn
);

  logic [2:0] ones;
  logic [1:0] line;

  assign stuff_now = (ones == 3'(USB_STUFF_LIMIT));
  assign dp = line[1];
  assign dn = line[0];

  // line state and ones run length, advanced once per bit time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line <= LINE_J;
      ones <= '0;
    end else if (bit_strobe) begin
      if (force_se0) begin
        line <= LINE_SE0;
        ones <= '0;
      end else if (force_j) begin
        line <= LINE_J;
        ones <= '0;
      end else if (no_stuff) begin
        if (!data_bit) line <= ~line;
        ones <= '0;
      end else if (stuff_now) begin
        line <= ~line;
        ones <= '0;
      end else if (data_bit) begin
        ones <= ones + 3'd1;
      end else begin
        line <= ~line;
        ones <= '0;
      end
    end
  end

endmodule

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: full-speed USB transmitter (SYNC, stuffing, NRZI, EOP).
// Optional abort sequence enabled by USB_FS_TX_ABORT_EN.
module usb_fs_tx
  import usb_pkg::*;
#(
  parameter int CLK_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_abort,
  output logic       tx_active,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       tx_oe
);

  localparam int TW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;

  usb_fs_tx_state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [7:0] sh, sh_nx;
  logic [3:0] cnt, cnt_nx;
  logic oe, oe_nx;
  logic strobe, consume, abort_req;
  logic data_bit, no_stuff, force_se0, force_j, stuff_now;

  assign strobe = (state != ST_IDLE) && (timer == '0);
  assign tx_ready = consume;
  assign tx_oe = oe;
  assign tx_active = oe;

`ifdef USB_FS_TX_ABORT_EN
  logic abort_q;

  // hold a short abort pulse until the next bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) abort_q <= 1'b0;
    else if (state != ST_SYNC && state != ST_DATA) abort_q <= 1'b0;
    else if (tx_abort) abort_q <= 1'b1;
  end

  assign abort_req = abort_q | tx_abort;
`else
  logic unused_abort;
  assign unused_abort = tx_abort;
  assign abort_req = 1'b0;
`endif

  // bit timer, free running while a packet is on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timer <= '0;
    else if (state == ST_IDLE) timer <= '0;
    else if (timer == TW'(CLK_PER_BIT - 1)) timer <= '0;
    else timer <= timer + 1'b1;
  end

  // state, shifter and output enable registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sh <= '0;
      cnt <= '0;
      oe <= 1'b0;
    end else begin
      state <= state_nx;
      sh <= sh_nx;
      cnt <= cnt_nx;
      oe <= oe_nx;
    end
  end

  // next state and per-bit symbol selection
  always_comb begin
    state_nx = state;
    sh_nx = sh;
    cnt_nx = cnt;
    oe_nx = oe;
    data_bit = 1'b1;
    no_stuff = 1'b0;
    force_se0 = 1'b0;
    force_j = 1'b0;
    consume = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          state_nx = ST_SYNC;
          sh_nx = USB_SYNC_BYTE;
          cnt_nx = '0;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (strobe) begin
          oe_nx = 1'b1;
          if (abort_req) begin
            state_nx = ST_ABORT;
            no_stuff = 1'b1;
            cnt_nx = 4'd1;
          end else if (stuff_now) begin
            cnt_nx = cnt;
          end else if (cnt != 4'd8) begin
            data_bit = sh[0];
            sh_nx = {1'b0, sh[7:1]};
            cnt_nx = cnt + 4'd1;
          end else if (tx_valid) begin
            consume = 1'b1;
            data_bit = tx_data[0];
            sh_nx = {1'b0, tx_data[7:1]};
            cnt_nx = 4'd1;
            state_nx = ST_DATA;
          end else begin
            force_se0 = 1'b1;
            cnt_nx = 4'd1;
            state_nx = ST_EOP_SE0;
          end
        end
      end
`ifdef USB_FS_TX_ABORT_EN
      ST_ABORT: begin
        if (strobe) begin
          if (cnt != 4'd8) begin
            no_stuff = 1'b1;
            cnt_nx = cnt + 4'd1;
          end else begin
            force_se0 = 1'b1;
            cnt_nx = 4'd1;
            state_nx = ST_EOP_SE0;
          end
        end
      end
`endif
      ST_EOP_SE0: begin
        if (strobe) begin
          if (cnt != 4'(USB_EOP_SE0_BITS)) begin
            force_se0 = 1'b1;
            cnt_nx = cnt + 4'd1;
          end else begin
            force_j = 1'b1;
            state_nx = ST_EOP_J;
          end
        end
      end
      ST_EOP_J: begin
        if (strobe) begin
          force_j = 1'b1;
          oe_nx = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  usb_fs_tx_nrzi u_nrzi (
    .clk(clk),
    .rst_n(rst_n),
    .bit_strobe(strobe),
    .data_bit(data_bit),
    .no_stuff(no_stuff),
    .force_se0(force_se0),
    .force_j(force_j),
    .stuff_now(stuff_now),
    .dp(dp_tx),
    .dn(dn_tx)
  );

endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx: scoreboard bench for usb_fs_tx line encoding.
// Expected line symbols and tx_ready offsets are queued per packet.
module tb_usb_fs_tx;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] S = 2'b00;

  localparam logic [1:0] D2_DATA [8] = '{J, J, K, J, J, K, K, K};
  localparam logic [1:0] FF_DATA [9] = '{K, K, K, K, K, J, J, J, J};

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_abort;
  logic tx_active;
  logic dp_tx;
  logic dn_tx;
  logic tx_oe;
  logic mon_en;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] sym_q[$];
  int rdy_q[$];
  int len_q[$];
  logic [1:0] s[$];
  int r[$];

  usb_fs_tx dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_abort(tx_abort),
    .tx_active(tx_active),
    .dp_tx(dp_tx),
    .dn_tx(dn_tx),
    .tx_oe(tx_oe)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_sync();
    for (int i = 0; i < 8; i++) s.push_back((i % 2 == 0 || i == 7) ? K : J);
  endtask

  task automatic add_eop();
    s.push_back(S);
    s.push_back(S);
    s.push_back(J);
  endtask

  task automatic add_alt(input int n);
    for (int i = 0; i < n; i++) s.push_back((i % 2 == 0) ? J : K);
  endtask

  task automatic commit();
    foreach (s[i]) sym_q.push_back(s[i]);
    foreach (r[i]) rdy_q.push_back(r[i]);
    len_q.push_back(s.size() * 4);
    s.delete();
    r.delete();
  endtask

  task automatic send(input logic [7:0] b[$]);
    int i;
    int t;
    bit seen;
    i = 0;
    seen = 0;
    tx_data = b[0];
    tx_valid = 1'b1;
    while (i < b.size()) begin
      t = 0;
      forever begin
        @(negedge clk);
        t++;
        if (tx_active) seen = 1;
        if (tx_ready || (seen && !tx_active) || t > 3000) break;
      end
      if (tx_ready) begin
        @(posedge clk);
        #1;
        i++;
        if (i < b.size()) tx_data = b[i];
        else tx_valid = 1'b0;
      end else begin
        tx_valid = 1'b0;
        if (t > 3000) chk("ready_timeout", t, 0);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((tx_active || tx_oe) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("idle_timeout", t, 0);
    repeat (3) @(negedge clk);
  endtask

  // monitor: compares line symbols and ready timing against the queues
  initial begin
    int k;
    bit in_pkt;
    k = 0;
    in_pkt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_pkt = 0;
      end else if (tx_oe) begin
        if (!in_pkt) begin
          in_pkt = 1;
          k = 0;
        end
        if (k % 4 == 0) begin
          if (sym_q.size() == 0) chk("sym_extra", k / 4, -1);
          else chk("line_sym", int'({dp_tx, dn_tx}), int'(sym_q.pop_front()));
          chk("active_hi", int'(tx_active), 1);
        end
        if (tx_ready) begin
          if (rdy_q.size() == 0) chk("ready_extra", k, -1);
          else chk("ready_at", k, rdy_q.pop_front());
        end
        k++;
      end else if (in_pkt) begin
        in_pkt = 0;
        chk("active_clks", k, (len_q.size() > 0) ? len_q.pop_front() : -1);
        chk("sym_left", sym_q.size(), 0);
        chk("ready_left", rdy_q.size(), 0);
        chk("idle_line", int'({dp_tx, dn_tx}), int'(J));
        chk("active_lo", int'(tx_active), 0);
      end
    end
  end

  initial begin
    logic [7:0] pk[$];

    rst_n = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    tx_abort = 1'b0;
    mon_en = 1'b1;
    #23;
    chk("rst_dp", int'(dp_tx), 1);
    chk("rst_dn", int'(dn_tx), 0);
    chk("rst_oe", int'(tx_oe), 0);
    chk("rst_active", int'(tx_active), 0);
    chk("rst_ready", int'(tx_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    tx_abort = 1'b1;
    repeat (5) @(negedge clk);
    tx_abort = 1'b0;
    chk("idle_abort_oe", int'(tx_oe), 0);

    add_sync();
    foreach (D2_DATA[i]) s.push_back(D2_DATA[i]);
    add_eop();
    r.push_back(31);
    commit();
    pk = '{8'hD2};
    send(pk);
    wait_idle();

    add_sync();
    foreach (FF_DATA[i]) s.push_back(FF_DATA[i]);
    add_eop();
    r.push_back(31);
    commit();
    pk = '{8'hFF};
    send(pk);
    wait_idle();

    add_sync();
    add_alt(24);
    add_eop();
    r.push_back(31);
    r.push_back(63);
    r.push_back(95);
    commit();
    pk = '{8'h00, 8'h00, 8'h00};
    send(pk);
    wait_idle();

    add_sync();
`ifdef USB_FS_TX_ABORT_EN
    add_alt(10);
    for (int i = 0; i < 8; i++) s.push_back(K);
    r.push_back(31);
    r.push_back(63);
`else
    add_alt(32);
    r.push_back(31);
    r.push_back(63);
    r.push_back(95);
    r.push_back(127);
`endif
    add_eop();
    commit();
    pk = '{8'h00, 8'h00, 8'h00, 8'h00};
    fork
      send(pk);
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!tx_oe && t < 100);
        repeat (70) @(negedge clk);
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
      end
    join
    wait_idle();

    mon_en = 1'b0;
    tx_data = 8'h00;
    tx_valid = 1'b1;
    repeat (50) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dp", int'(dp_tx), 1);
    chk("mid_rst_dn", int'(dn_tx), 0);
    chk("mid_rst_oe", int'(tx_oe), 0);
    chk("mid_rst_active", int'(tx_active), 0);
    tx_valid = 1'b0;
    sym_q.delete();
    rdy_q.delete();
    len_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    add_sync();
    foreach (D2_DATA[i]) s.push_back(D2_DATA[i]);
    add_eop();
    r.push_back(31);
    commit();
    pk = '{8'hD2};
    send(pk);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
